// File: rtl/ean13_pkg.sv
// Shared EAN-13 definitions: code geometry, FSM state encoding and a digit-extract helper.
package ean13_pkg;

    localparam int unsigned EAN13_DIGITS  = 13;
    localparam int unsigned EAN13_DIGIT_W = 4;
    localparam int unsigned EAN13_CODE_W  = 52;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_FINAL   = 2'd2,
        ST_COMPARE = 2'd3
    } ean13_state_e;

    // Digit k (0 = leading, 12 = check digit) sits at [51-4k -: 4].
    function automatic logic [EAN13_DIGIT_W-1:0] ean13_digit(
        input logic [EAN13_CODE_W-1:0] code,
        input logic [3:0]              k
    );
        logic [EAN13_CODE_W-1:0] sh;
        sh = code >> (EAN13_DIGIT_W * (EAN13_DIGITS - 1 - 32'(k)));
        return sh[EAN13_DIGIT_W-1:0];
    endfunction

endpackage

// File: rtl/ean13_checksum_seq.sv
// Sequential EAN-13 check-digit verifier: one weighted digit per clock, then a final
// compare of the computed check digit against digit 12.
module ean13_checksum_seq
    import ean13_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [EAN13_CODE_W-1:0] i_code,
    output logic                    o_done,
    output logic                    o_ok
);

    localparam int unsigned SUM_W = 8;
    localparam int unsigned IDX_W = 4;

    ean13_state_e             r_state, w_state_nxt;
    logic [EAN13_CODE_W-1:0]  r_code, w_code_nxt;
    logic [SUM_W-1:0]         r_sum, w_sum_nxt;
    logic [IDX_W-1:0]         r_idx, w_idx_nxt;
    logic                     r_bad, w_bad_nxt;
    logic                     r_done, w_done_nxt;
    logic                     r_ok, w_ok_nxt;

    logic [EAN13_DIGIT_W-1:0] w_digit;
    logic [EAN13_DIGIT_W-1:0] w_check;
    logic [SUM_W-1:0]         w_weighted;
    logic [SUM_W-1:0]         w_expected;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_code  <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_bad   <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_sum   <= w_sum_nxt;
            r_idx   <= w_idx_nxt;
            r_bad   <= w_bad_nxt;
            r_done  <= w_done_nxt;
            r_ok    <= w_ok_nxt;
        end
    end

    // Odd positions weigh 3, even positions 1; max sum 216 fits 8 bits.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_sum_nxt   = r_sum;
        w_idx_nxt   = r_idx;
        w_bad_nxt   = r_bad;
        w_done_nxt  = 1'b0;
        w_ok_nxt    = r_ok;

        w_digit    = ean13_digit(r_code, r_idx);
        w_check    = ean13_digit(r_code, 4'd12);
        w_weighted = r_idx[0] ? SUM_W'(w_digit) * SUM_W'(3) : SUM_W'(w_digit);
        w_expected = (SUM_W'(10) - (r_sum % SUM_W'(10))) % SUM_W'(10);

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_code_nxt  = i_code;
                    w_sum_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_bad_nxt   = 1'b0;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_sum_nxt = r_sum + w_weighted;
                if (w_digit > EAN13_DIGIT_W'(9)) begin
                    w_bad_nxt = 1'b1;
                end
                if (r_idx == IDX_W'(11)) begin
                    w_state_nxt = ST_FINAL;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            ST_FINAL: begin
                w_ok_nxt    = !r_bad && (w_check <= EAN13_DIGIT_W'(9))
                              && (w_expected == SUM_W'(w_check));
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_done = r_done;
    assign o_ok   = r_ok;

endmodule

// File: rtl/ean13_code_validator.sv
// EAN-13 candidate filter: checksum-verifies each candidate and publishes a code after
// CONFIRM_COUNT identical valid repeats. Optional error counter: EAN13_VALIDATOR_ERRCNT_EN.
module ean13_code_validator
    import ean13_pkg::*;
#(
    parameter int unsigned CONFIRM_COUNT  = 3,
    parameter int unsigned TIMEOUT_FRAMES = 30
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic [EAN13_CODE_W-1:0] iDataCode,
    input  logic                    iNewData,
    input  logic                    iFrameStart,
    output logic [EAN13_CODE_W-1:0] oCode,
    output logic                    oCodeValid,
    output logic                    oNewCode,
    output logic                    oChecksumErr,
    output logic [15:0]             oErrCount,
    output logic                    oBusy
);

    localparam int unsigned MATCH_W  = 4;
    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned ERRCNT_W = 16;

    ean13_state_e            r_state, w_state_nxt;
    logic [EAN13_CODE_W-1:0] r_cand, w_cand_nxt;
    logic [EAN13_CODE_W-1:0] r_last_cand, w_last_cand_nxt;
    logic [MATCH_W-1:0]      r_match, w_match_nxt;
    logic [FRAME_W-1:0]      r_frames, w_frames_nxt;
    logic [EAN13_CODE_W-1:0] r_code, w_code_nxt;
    logic                    r_code_valid, w_code_valid_nxt;
    logic                    r_new_code, w_new_code_nxt;
    logic                    r_chk_err, w_chk_err_nxt;
    logic                    r_busy, w_busy_nxt;
`ifdef EAN13_VALIDATOR_ERRCNT_EN
    logic [ERRCNT_W-1:0]     r_err_cnt, w_err_cnt_nxt;
`endif

    logic                    w_start;
    logic                    w_done;
    logic                    w_ok;
    logic                    w_ok_cmp;
    logic                    w_frame_evt;
    logic [FRAME_W-1:0]      w_frames_inc;

    assign w_start = (r_state == ST_IDLE) && iNewData;

    ean13_checksum_seq u_checksum (
        .i_clk   (iClk),
        .i_rst   (iRst),
        .i_start (w_start),
        .i_code  (iDataCode),
        .o_done  (w_done),
        .o_ok    (w_ok)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state      <= ST_IDLE;
            r_cand       <= '0;
            r_last_cand  <= '0;
            r_match      <= '0;
            r_frames     <= '0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_new_code   <= 1'b0;
            r_chk_err    <= 1'b0;
            r_busy       <= 1'b0;
`ifdef EAN13_VALIDATOR_ERRCNT_EN
            r_err_cnt    <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cand       <= w_cand_nxt;
            r_last_cand  <= w_last_cand_nxt;
            r_match      <= w_match_nxt;
            r_frames     <= w_frames_nxt;
            r_code       <= w_code_nxt;
            r_code_valid <= w_code_valid_nxt;
            r_new_code   <= w_new_code_nxt;
            r_chk_err    <= w_chk_err_nxt;
            r_busy       <= w_busy_nxt;
`ifdef EAN13_VALIDATOR_ERRCNT_EN
            r_err_cnt    <= w_err_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cand_nxt       = r_cand;
        w_last_cand_nxt  = r_last_cand;
        w_match_nxt      = r_match;
        w_frames_nxt     = r_frames;
        w_code_nxt       = r_code;
        w_code_valid_nxt = r_code_valid;
        w_new_code_nxt   = 1'b0;
        w_chk_err_nxt    = 1'b0;
        w_busy_nxt       = r_busy;
`ifdef EAN13_VALIDATOR_ERRCNT_EN
        w_err_cnt_nxt    = r_err_cnt;
`endif

        // A valid result resets the frame counter, so it masks a same-cycle frame pulse.
        w_ok_cmp     = (r_state == ST_COMPARE) && w_ok;
        w_frame_evt  = iFrameStart && !w_ok_cmp;
        w_frames_inc = r_frames + FRAME_W'(1);

        if (w_frame_evt) begin
            if ((TIMEOUT_FRAMES != 0) && (w_frames_inc == FRAME_W'(TIMEOUT_FRAMES))) begin
                w_code_valid_nxt = 1'b0;
                w_match_nxt      = '0;
                w_frames_nxt     = '0;
            end else begin
                w_frames_nxt = w_frames_inc;
            end
        end

        case (r_state)
            ST_IDLE: begin
                if (iNewData) begin
                    w_cand_nxt  = iDataCode;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_done) begin
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                if (!w_ok) begin
                    w_chk_err_nxt = 1'b1;
                    w_match_nxt   = '0;
`ifdef EAN13_VALIDATOR_ERRCNT_EN
                    if (r_err_cnt != {ERRCNT_W{1'b1}}) begin
                        w_err_cnt_nxt = r_err_cnt + ERRCNT_W'(1);
                    end
`endif
                end else begin
                    if (r_cand == r_last_cand) begin
                        w_match_nxt = (r_match >= MATCH_W'(CONFIRM_COUNT))
                                      ? r_match : r_match + MATCH_W'(1);
                    end else begin
                        w_last_cand_nxt = r_cand;
                        w_match_nxt     = MATCH_W'(1);
                    end
                    w_frames_nxt = '0;
                    // Re-confirming the code already on display stays silent.
                    if ((w_match_nxt == MATCH_W'(CONFIRM_COUNT))
                        && (!r_code_valid || (r_code != r_cand))) begin
                        w_code_nxt       = r_cand;
                        w_code_valid_nxt = 1'b1;
                        w_new_code_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign oCode        = r_code;
    assign oCodeValid   = r_code_valid;
    assign oNewCode     = r_new_code;
    assign oChecksumErr = r_chk_err;
    assign oBusy        = r_busy;
`ifdef EAN13_VALIDATOR_ERRCNT_EN
    assign oErrCount    = r_err_cnt;
`else
    assign oErrCount    = '0;
`endif

endmodule

// File: tb/tb_ean13_code_validator.sv
// Directed scoreboard bench for ean13_code_validator (CONFIRM_COUNT=3, TIMEOUT_FRAMES=2).
module tb_ean13_code_validator;

    localparam logic [51:0] CODE_A     = 52'h4006381333931;
    localparam logic [51:0] CODE_BADCK = 52'h4006381333932;
    localparam logic [51:0] CODE_NBCD  = 52'h40063813339A1;
    localparam logic [51:0] CODE_C     = 52'h5901234123457;
    localparam int CC  = 3;
    localparam int TO  = 2;
    localparam int LAT = 15;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic [51:0] iDataCode = '0;
    logic        iNewData = 1'b0;
    logic        iFrameStart = 1'b0;
    logic [51:0] oCode;
    logic        oCodeValid;
    logic        oNewCode;
    logic        oChecksumErr;
    logic [15:0] oErrCount;
    logic        oBusy;

    ean13_code_validator #(
        .CONFIRM_COUNT  (CC),
        .TIMEOUT_FRAMES (TO)
    ) dut (
        .iClk         (iClk),
        .iRst         (iRst),
        .iDataCode    (iDataCode),
        .iNewData     (iNewData),
        .iFrameStart  (iFrameStart),
        .oCode        (oCode),
        .oCodeValid   (oCodeValid),
        .oNewCode     (oNewCode),
        .oChecksumErr (oChecksumErr),
        .oErrCount    (oErrCount),
        .oBusy        (oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic        new_code;
        logic        chk_err;
        logic [51:0] code;
        logic        valid;
        logic [15:0] err_cnt;
        int          start_cyc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nc_seen = 0;
    int nc_exp = 0;

    logic [51:0] m_last = '0;
    int          m_match = 0;
    logic [51:0] m_code = '0;
    logic        m_valid = 1'b0;
    int          m_err = 0;
    int          m_frames = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cksum_ok(input logic [51:0] c);
        int sum = 0;
        logic nonbcd = 1'b0;
        logic [3:0] dk = '0;
        for (int k = 0; k < 13; k++) begin
            dk = c[51-4*k -: 4];
            if (dk > 4'd9) nonbcd = 1'b1;
            if (k < 12) sum += int'(dk) * ((k % 2) ? 3 : 1);
        end
        return !nonbcd && (((10 - (sum % 10)) % 10) == int'(dk));
    endfunction

    // Reference model for one accepted candidate; pushes the expected post-result state.
    task automatic model_push(input logic [51:0] c);
        exp_t e;
        e.new_code = 1'b0;
        e.chk_err  = 1'b0;
        if (!cksum_ok(c)) begin
            e.chk_err = 1'b1;
            m_match = 0;
`ifdef EAN13_VALIDATOR_ERRCNT_EN
            if (m_err < 65535) m_err++;
`endif
        end else begin
            if (c == m_last) begin
                if (m_match < CC) m_match++;
            end else begin
                m_last = c;
                m_match = 1;
            end
            m_frames = 0;
            if (m_match == CC && (!m_valid || m_code != c)) begin
                m_code = c;
                m_valid = 1'b1;
                e.new_code = 1'b1;
                nc_exp++;
            end
        end
        e.code      = m_code;
        e.valid     = m_valid;
        e.err_cnt   = 16'(m_err);
        e.start_cyc = cyc + 1;
        q.push_back(e);
    endtask

    // Result monitor: every busy fall is one finished candidate.
    logic prev_busy = 1'b0;
    always @(negedge iClk) begin : mon
        exp_t e;
        if (iRst) begin
            prev_busy = 1'b0;
        end else begin
            if (oNewCode) nc_seen++;
            if (prev_busy && !oBusy) begin
                if (q.size() == 0) begin
                    check("result_without_strobe", 64'(q.size()), 64'd1);
                end else begin
                    e = q.pop_front();
                    check("new_code_pulse", 64'(oNewCode), 64'(e.new_code));
                    check("chk_err_pulse", 64'(oChecksumErr), 64'(e.chk_err));
                    check("code", 64'(oCode), 64'(e.code));
                    check("code_valid", 64'(oCodeValid), 64'(e.valid));
                    check("err_count", 64'(oErrCount), 64'(e.err_cnt));
                    check("latency", 64'(cyc), 64'(e.start_cyc + LAT));
                end
            end else begin
                check("stray_pulse", 64'({oNewCode, oChecksumErr}), 64'd0);
            end
            prev_busy = oBusy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    task automatic strobe(input logic [51:0] c, input bit accepted);
        iDataCode = c;
        iNewData = 1'b1;
        if (accepted) model_push(c);
        tick(1);
        iNewData = 1'b0;
    endtask

    task automatic send(input logic [51:0] c);
        strobe(c, 1'b1);
        check("busy_after_strobe", 64'(oBusy), 64'd1);
        tick(19);
        check("result_pending", 64'(q.size()), 64'd0);
    endtask

    task automatic frame_pulse();
        iFrameStart = 1'b1;
        m_frames++;
        if (TO != 0 && m_frames == TO) begin
            m_valid = 1'b0;
            m_match = 0;
            m_frames = 0;
        end
        tick(1);
        iFrameStart = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_code"}, 64'(oCode), 64'd0);
        check({tag, "_valid"}, 64'(oCodeValid), 64'd0);
        check({tag, "_newcode"}, 64'(oNewCode), 64'd0);
        check({tag, "_chkerr"}, 64'(oChecksumErr), 64'd0);
        check({tag, "_errcnt"}, 64'(oErrCount), 64'd0);
        check({tag, "_busy"}, 64'(oBusy), 64'd0);
    endtask

    initial begin
        tick(3);
        check_reset_outputs("reset");
        iRst = 1'b0;
        tick(2);

        // Confirm CODE_A with three identical valid candidates.
        send(CODE_A);
        send(CODE_A);
        send(CODE_A);
        check("confirm_code", 64'(oCode), 64'(CODE_A));
        check("confirm_valid", 64'(oCodeValid), 64'd1);
        check("confirm_count", 64'(nc_seen), 64'd1);

        // Wrong check digit, then a non-BCD digit: errors, lock untouched.
        send(CODE_BADCK);
        check("badck_valid_kept", 64'(oCodeValid), 64'd1);
        send(CODE_NBCD);
        check("nbcd_code_kept", 64'(oCode), 64'(CODE_A));

        // Re-confirming the held code must not pulse oNewCode again.
        send(CODE_A);
        send(CODE_A);
        send(CODE_A);
        check("reconfirm_no_pulse", 64'(nc_seen), 64'(nc_exp));

        // Broken sequence restarts the match count; then confirm CODE_C.
        send(CODE_C);
        send(CODE_C);
        send(CODE_A);
        send(CODE_C);
        check("break_no_pulse", 64'(nc_seen), 64'd1);
        send(CODE_C);
        send(CODE_C);
        check("confirm_c", 64'(oCode), 64'(CODE_C));
        check("confirm_c_count", 64'(nc_seen), 64'd2);

        // Strobe while busy is ignored.
        strobe(CODE_A, 1'b1);
        tick(4);
        strobe(CODE_C, 1'b0);
        tick(20);
        check("busy_strobe_pending", 64'(q.size()), 64'd0);
        check("busy_strobe_count", 64'(nc_seen), 64'(nc_exp));

        // Two frame pulses with no valid candidate drop the lock, code retained.
        frame_pulse();
        tick(1);
        frame_pulse();
        tick(2);
        check("timeout_valid", 64'(oCodeValid), 64'(m_valid));
        check("timeout_valid_low", 64'(oCodeValid), 64'd0);
        check("timeout_code_kept", 64'(oCode), 64'(CODE_C));

        // Reset in the middle of a check.
        strobe(CODE_A, 1'b1);
        tick(5);
        iRst = 1'b1;
        q.delete();
        tick(2);
        check_reset_outputs("midreset");
        m_last = '0;
        m_match = 0;
        m_code = '0;
        m_valid = 1'b0;
        m_err = 0;
        m_frames = 0;
        iRst = 1'b0;
        tick(2);

        // Fresh confirmation after reset.
        send(CODE_A);
        send(CODE_A);
        send(CODE_A);
        check("post_reset_code", 64'(oCode), 64'(CODE_A));
        check("post_reset_count", 64'(nc_seen), 64'(nc_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
